// File: rtl/rr_arbiter_enc.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_enc
// Purpose  : 8-requester round-robin arbiter with a binary-encoded grant.
//            gnt_idx feeds a 3-to-8 decoder's in[2:0] and gnt_en feeds its
//            enable, so downstream sees a one-hot grant bus. Every grant is
//            followed by one GAP cycle so two owners never overlap.
// Ports    : clk          - rising-edge clock
//            rst_n        - asynchronous reset, active-low
//            req[7:0]     - request lines, req[i]=1 -> requester i wants bus
//            done         - 1-cycle pulse, current owner finished
//            gnt_idx[2:0] - encoded index of granted requester (registered)
//            gnt_en       - grant valid (registered)
//            timeout_flag - 1-cycle pulse on forced release (registered)
// Config   : RR_ARB_TIMEOUT_EN - when defined, a grant held TIMEOUT cycles
//            without release is forcibly released and timeout_flag pulses.
//            When undefined, timeout_flag is tied low and TIMEOUT is unused.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_enc #(
    parameter int TIMEOUT = 16      // legal 2..255, timeout build only
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic       gnt_en,
    output logic       timeout_flag
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_grant = 2'd1;
    localparam logic [1:0] c_gap   = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] r_ptr;              // index of the most recent owner
    logic [2:0] w_ptr_nxt;
    logic [2:0] r_gnt_idx;
    logic [2:0] w_gnt_idx_nxt;
    logic       r_gnt_en;
    logic       w_gnt_en_nxt;
    logic [2:0] w_winner;
    logic [2:0] w_cand;
    logic       w_release;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] c_hold_last = 8'(TIMEOUT - 1);

    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_cnt_nxt;
    logic       r_timeout_flag;
    logic       w_timeout_flag_nxt;
`endif

    // Round-robin search. Walking offsets from 8 down to 1 lets the
    // closest requester after r_ptr overwrite farther ones; offset 8
    // wraps to r_ptr itself, so the last owner has the lowest priority.
    always_comb begin
        w_winner = 3'd0;
        w_cand   = 3'd0;
        for (int i = 8; i >= 1; i--) begin
            w_cand = r_ptr + 3'(i);
            if (req[w_cand]) begin
                w_winner = w_cand;
            end
        end
    end

    // done and a dropped request on the same edge collapse into one release.
    assign w_release = done | ~req[r_gnt_idx];

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_idx_nxt = r_gnt_idx;
        w_gnt_en_nxt  = r_gnt_en;
`ifdef RR_ARB_TIMEOUT_EN
        w_hold_cnt_nxt     = r_hold_cnt;
        w_timeout_flag_nxt = 1'b0;
`endif
        case (r_state)
            c_idle: begin
                w_gnt_en_nxt = 1'b0;
                if (|req) begin
                    w_gnt_idx_nxt = w_winner;
                    w_gnt_en_nxt  = 1'b1;
                    w_state_nxt   = c_grant;
`ifdef RR_ARB_TIMEOUT_EN
                    w_hold_cnt_nxt = 8'd0;
`endif
                end
            end
            c_grant: begin
                if (w_release) begin
                    w_gnt_en_nxt = 1'b0;
                    w_ptr_nxt    = r_gnt_idx;
                    w_state_nxt  = c_gap;
                end
`ifdef RR_ARB_TIMEOUT_EN
                // Normal release has priority, so the flag only fires when
                // the owner is still holding on at the final cycle.
                else if (r_hold_cnt == c_hold_last) begin
                    w_gnt_en_nxt       = 1'b0;
                    w_ptr_nxt          = r_gnt_idx;
                    w_state_nxt        = c_gap;
                    w_timeout_flag_nxt = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
`endif
            end
            c_gap: begin
                w_gnt_en_nxt = 1'b0;
                w_state_nxt  = c_idle;
            end
            default: begin
                w_gnt_en_nxt = 1'b0;
                w_state_nxt  = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_ptr     <= 3'd7;
            r_gnt_idx <= 3'd0;
            r_gnt_en  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_gnt_en  <= w_gnt_en_nxt;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt     <= 8'd0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_hold_cnt     <= w_hold_cnt_nxt;
            r_timeout_flag <= w_timeout_flag_nxt;
        end
    end

    assign timeout_flag = r_timeout_flag;
`else
    assign timeout_flag = 1'b0;
`endif

    assign gnt_idx = r_gnt_idx;
    assign gnt_en  = r_gnt_en;

endmodule
`default_nettype wire
